// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: ASCII register-access command parser between UART RX/TX FIFOs.
// Lines "Wxxyy<CR>" write, "Rxx<CR>" read; replies "K\r\n", "hh\r\n" or "E\r\n".
// Optional build macro UART_CMD_ECHO_EN: echo every popped byte to the TX FIFO.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data_out,
  output logic       rx_fifo_read_en,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_fifo_data_in,
  output logic       tx_fifo_write_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_write,
  output logic       reg_read,
  input  logic [7:0] reg_rdata
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, POP, COLLECT, EXEC, RDWAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [7:0]    line_q [MAX_LEN];
  logic [7:0]    line_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          is_rd_q, is_rd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    resp_q [4];
  logic [7:0]    resp_d [4];
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_q, last_d;

  logic [7:0]    ch [5];
  logic [7:0]    cmd_up;
  logic          is_w, is_r, dec_err, collect_go;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters A-F/a-f share low nibble 1..6, so +9 yields 10..15 for both cases.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] nib_chr(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Decode the stored line as a command (evaluated when CR arrives)
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      ch[i] = 8'h00;
      if (i < MAX_LEN) ch[i] = line_q[i];
    end
    cmd_up  = ch[0] & 8'hDF;
    is_w    = (cmd_up == 8'h57);
    is_r    = (cmd_up == 8'h52);
    dec_err = ovf_q ||
              !((is_w && len_q == LW'(5) && is_hex(ch[1]) && is_hex(ch[2]) &&
                 is_hex(ch[3]) && is_hex(ch[4])) ||
                (is_r && len_q == LW'(3) && is_hex(ch[1]) && is_hex(ch[2])));
  end

  // Next-state and output logic
  always_comb begin
    state_d          = state_q;
    rx_byte_d        = rx_byte_q;
    line_d           = line_q;
    len_d            = len_q;
    ovf_d            = ovf_q;
    err_d            = err_q;
    is_rd_d          = is_rd_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    resp_d           = resp_q;
    idx_d            = idx_q;
    last_d           = last_q;
    rx_fifo_read_en  = 1'b0;
    tx_fifo_data_in  = 8'h00;
    tx_fifo_write_en = 1'b0;
    reg_write        = 1'b0;
    reg_read         = 1'b0;
    collect_go       = 1'b1;

    case (state_q)
      IDLE: if (!rx_fifo_empty) state_d = POP;
      POP: begin
        rx_fifo_read_en = 1'b1;
        rx_byte_d       = rx_fifo_data_out;
        state_d         = COLLECT;
      end
      COLLECT: begin
`ifdef UART_CMD_ECHO_EN
        tx_fifo_data_in  = rx_byte_q;
        tx_fifo_write_en = !tx_fifo_full;
        collect_go       = !tx_fifo_full;
`endif
        if (collect_go) begin
          if (rx_byte_q == 8'h0A) begin
            state_d = IDLE;
          end else if (rx_byte_q == 8'h0D) begin
            if (len_q == '0) begin
              state_d = IDLE;
            end else begin
              err_d   = dec_err;
              is_rd_d = is_r;
              if (!dec_err) begin
                addr_d = {hex_val(ch[1]), hex_val(ch[2])};
                if (is_w) wdata_d = {hex_val(ch[3]), hex_val(ch[4])};
              end
              state_d = EXEC;
            end
          end else begin
            if (len_q < LW'(MAX_LEN)) begin
              for (int unsigned i = 0; i < MAX_LEN; i++)
                if (len_q == LW'(i)) line_d[i] = rx_byte_q;
              len_d = len_q + LW'(1);
            end else begin
              ovf_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
      end
      EXEC: begin
        idx_d = 2'd0;
        if (err_q) begin
          resp_d  = '{8'h45, 8'h0D, 8'h0A, 8'h00};
          last_d  = 2'd2;
          state_d = RESP;
        end else if (is_rd_q) begin
          reg_read = 1'b1;
          state_d  = RDWAIT;
        end else begin
          reg_write = 1'b1;
          resp_d    = '{8'h4B, 8'h0D, 8'h0A, 8'h00};
          last_d    = 2'd2;
          state_d   = RESP;
        end
      end
      RDWAIT: begin
        resp_d  = '{nib_chr(reg_rdata[7:4]), nib_chr(reg_rdata[3:0]), 8'h0D, 8'h0A};
        last_d  = 2'd3;
        state_d = RESP;
      end
      RESP: begin
        tx_fifo_data_in = resp_q[idx_q];
        if (!tx_fifo_full) begin
          tx_fifo_write_en = 1'b1;
          if (idx_q == last_q) begin
            len_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            is_rd_d = 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) line_d[i] = 8'h00;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rx_byte_q <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) line_q[i] <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) resp_q[i] <= '0;
      idx_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      rx_byte_q <= rx_byte_d;
      line_q    <= line_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser with FIFO and register models.
module tb_uart_cmd_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_fifo_empty;
  logic [7:0] rx_fifo_data_out;
  logic       rx_fifo_read_en;
  logic       tx_fifo_full;
  logic [7:0] tx_fifo_data_in;
  logic       tx_fifo_write_en;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_write, reg_read;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         checks = 0, errors = 0;
  int         wr_cnt = 0, rd_cnt = 0, pop_cnt = 0, sent_cnt = 0;
  int         txsnap, popsnap, n;
  logic [7:0] wr_addr = 0, wr_data = 0, rd_addr = 0, rd_value = 0;
  logic       rd_seen;

  always #5 clock = ~clock;

  uart_cmd_parser #(.MAX_LEN(5)) dut (
    .clock(clock), .reset(reset),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data_out(rx_fifo_data_out),
    .rx_fifo_read_en(rx_fifo_read_en), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_data_in(tx_fifo_data_in), .tx_fifo_write_en(tx_fifo_write_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
    .reg_read(reg_read), .reg_rdata(reg_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rx_sync();
    rx_fifo_empty    = (rxq.size() == 0);
    rx_fifo_data_out = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
    sent_cnt += s.len();
    rx_sync();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (rxq.size() != 0 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_drain"}, rxq.size(), 0);
    repeat (25) @(negedge clock);
  endtask

  task automatic check_tx(input string tag, input string exp);
    int m;
    check({tag, "_txlen"}, txq.size(), exp.len());
    m = (txq.size() < exp.len()) ? txq.size() : exp.len();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_tx%0d", tag, i), txq[i], 32'(exp[i]));
    txq.delete();
  endtask

  function automatic string ex(input string rx, input string resp);
`ifdef UART_CMD_ECHO_EN
    return {rx, resp};
`else
    return resp;
`endif
  endfunction

  // RX FIFO model: pop shortly after the edge that saw the strobe
  always @(posedge clock) begin
    if (rx_fifo_read_en) begin
      #1;
      if (rxq.size() > 0) void'(rxq.pop_front());
      pop_cnt++;
      rx_sync();
    end
  end

  // TX FIFO capture and register-bus monitor
  always @(posedge clock) begin
    if (tx_fifo_write_en && !tx_fifo_full) txq.push_back(tx_fifo_data_in);
    if (reg_write) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_read) begin rd_cnt++; rd_addr = reg_addr; end
  end

  // Register read data is valid only in the cycle after reg_read
  always @(posedge clock) begin
    rd_seen = reg_read;
    #1 reg_rdata = rd_seen ? rd_value : 8'h00;
  end

  initial begin
    reset = 1'b0; tx_fifo_full = 1'b0; reg_rdata = 8'h00;
    rx_sync();
    repeat (3) @(negedge clock);
    check("rst_strobes", {28'h0, rx_fifo_read_en, tx_fifo_write_en, reg_write, reg_read}, 0);
    check("rst_data", {8'h0, tx_fifo_data_in, reg_addr, reg_wdata}, 0);
    reset = 1'b1;

    // Valid write at exactly MAX_LEN characters
    send("W1A5C\r"); drain("w1");
    check("w1_wcnt", wr_cnt, 1);
    check("w1_addr", wr_addr, 8'h1A);
    check("w1_data", wr_data, 8'h5C);
    check("w1_rcnt", rd_cnt, 0);
    check_tx("w1", ex("W1A5C\r", "K\r\n"));

    // Lower-case read
    rd_value = 8'hE7;
    send("r1a\r"); drain("r1");
    check("r1_rcnt", rd_cnt, 1);
    check("r1_addr", rd_addr, 8'h1A);
    check("r1_wcnt", wr_cnt, 1);
    check("r1_hold", reg_wdata, 8'h5C);
    check_tx("r1", ex("r1a\r", "E7\r\n"));

    // Errors: bad hex, bad letter, overflow, short write, overflow by one
    send("W1G00\rX12\rR123456\rW123\rW12345\r"); drain("er");
    check("er_wcnt", wr_cnt, 1);
    check("er_rcnt", rd_cnt, 1);
    check("er_addr", reg_addr, 8'h1A);
    check_tx("er", {ex("W1G00\r", "E\r\n"), ex("X12\r", "E\r\n"), ex("R123456\r", "E\r\n"),
                    ex("W123\r", "E\r\n"), ex("W12345\r", "E\r\n")});

    // Empty line is silent; LF ignored mid-line; mixed-case hex
    send("\r\nwA\nb0c\r"); drain("lf");
    check("lf_wcnt", wr_cnt, 2);
    check("lf_addr", wr_addr, 8'hAB);
    check("lf_data", wr_data, 8'h0C);
    check_tx("lf", ex("\r\nwA\nb0c\r", "K\r\n"));

    // TX backpressure during a read response, next line already queued
    rd_value = 8'h3C;
    send("R00\r");
    n = 0;
    while (rxq.size() != 0 && n < 200) begin @(negedge clock); n++; end
    tx_fifo_full = 1'b1;
    txsnap = txq.size(); popsnap = pop_cnt;
    send("W0102\r");
    repeat (20) @(negedge clock);
    check("st_pops", pop_cnt - popsnap, 0);
    check("st_tx", txq.size() - txsnap, 0);
    tx_fifo_full = 1'b0;
    drain("st");
    check("st_rcnt", rd_cnt, 2);
    check("st_wcnt", wr_cnt, 3);
    check("st_wdata", wr_data, 8'h02);
    check_tx("st", {ex("R00\r", "3C\r\n"), ex("W0102\r", "K\r\n")});

    // Reset mid-line
    send("W12"); drain("rs0");
    txq.delete();
    reset = 1'b0;
    #1;
    check("rs_strobes", {28'h0, rx_fifo_read_en, tx_fifo_write_en, reg_write, reg_read}, 0);
    check("rs_data", {8'h0, tx_fifo_data_in, reg_addr, reg_wdata}, 0);
    @(negedge clock);
    reset = 1'b1;
    rd_value = 8'hB4;
    send("R12\r"); drain("rs");
    check("rs_rcnt", rd_cnt, 3);
    check("rs_raddr", rd_addr, 8'h12);
    check("rs_wcnt", wr_cnt, 3);
    check_tx("rs", ex("R12\r", "B4\r\n"));

    // CR LF terminated read: LF is popped after the response
    rd_value = 8'h5A;
    send("R05\r\n"); drain("ec");
    check("ec_rcnt", rd_cnt, 4);
    check_tx("ec", {ex("R05\r", "5A\r\n"), ex("\n", "")});

    check("pop_total", pop_cnt, sent_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
